// File: rtl/adder_pkg.sv
// Shared defaults and operation encoding for the pipelined ripple-carry adder family.
package adder_pkg;

  localparam int unsigned ADD_WIDTH_DEF  = 32;
  localparam int unsigned ADD_STAGES_DEF = 4;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/pipelined_ripple_adder_rca_segment.sv
// Ripple-carry segment built from the full_adder cell; purely combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] s,
  output logic           cout
);

  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign cout = c[SEG];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH split into STAGES segments, one register
// stage per segment, whole-pipe stall driven by valid/ready flow control.
module pipelined_ripple_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = ADD_WIDTH_DEF,
  parameter int unsigned STAGES = ADD_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_err
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  op_e    op;
  logic   adv;
  stage_t head;
  stage_t tail;

  assign op        = op_e'(Sub);
  assign out_valid = tail.valid;
  assign adv       = out_ready | ~tail.valid;
  assign in_ready  = adv;

  // Stage-0 operand prep: subtraction is A + ~B + 1, so Cin is ignored in that mode.
  always_comb begin
    head       = '0;
    head.valid = in_valid & adv;
    head.carry = (op == OP_SUB) ? 1'b1 : Cin;
    head.a     = A;
    head.b     = (op == OP_SUB) ? ~B : B;
    head.a_msb = A[WIDTH-1];
    head.b_msb = head.b[WIDTH-1];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t           prev;
    stage_t           nxt;
    stage_t           r;
    logic [SEG-1:0]   seg_s;
    logic             seg_c;

    if (k == 0) begin : g_first
      assign prev = head;
    end else begin : g_next
      assign prev = g_stage[k-1].r;
    end

    rca_segment #(.SEG(SEG)) u_seg (
      .a    (prev.a[k*SEG +: SEG]),
      .b    (prev.b[k*SEG +: SEG]),
      .cin  (prev.carry),
      .s    (seg_s),
      .cout (seg_c)
    );

    always_comb begin
      nxt                   = prev;
      nxt.s[k*SEG +: SEG]   = seg_s;
      nxt.carry             = seg_c;
    end

    // Data only loads with a valid op so the output stage keeps its last result across bubbles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r <= '0;
      end else if (adv) begin
        if (prev.valid) begin
          r <= nxt;
        end else begin
          r.valid <= 1'b0;
        end
      end
    end
  end

  assign tail = g_stage[STAGES-1].r;
  assign S    = tail.s;
  assign Cout = tail.carry;
  assign Ovf  = (tail.a_msb == tail.b_msb) & (tail.s[WIDTH-1] != tail.a_msb);

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Self-checking bench: directed vector table, reset/backpressure sequences and a
// randomized parameter sweep scored against an arithmetic reference model.
module tb_pipelined_ripple_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main DUT: WIDTH=32, STAGES=4
  logic        m_iv, m_ir, m_cin, m_sub, m_ov, m_or, m_c, m_o;
  logic [31:0] m_a, m_b, m_s;

  pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(m_iv), .in_ready(m_ir), .A(m_a), .B(m_b),
    .Cin(m_cin), .Sub(m_sub), .out_valid(m_ov), .out_ready(m_or), .S(m_s),
    .Cout(m_c), .Ovf(m_o)
  );

  // Sweep DUTs share one 64-bit stimulus stream, sliced to each width.
  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_iv, sw_or;
  logic [15:0] s0, s1;
  logic [63:0] s2;
  logic        ir0, ir1, ir2, ov0, ov1, ov2, c0, c1, c2, o0, o1, o2;
  logic [63:0] sw_s  [3];
  logic        sw_ov [3];
  logic        sw_ir [3];
  logic        sw_c  [3];
  logic        sw_o  [3];

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(1)) u_sw0 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(ir0), .A(sw_a[15:0]), .B(sw_b[15:0]),
    .Cin(sw_cin), .Sub(sw_sub), .out_valid(ov0), .out_ready(sw_or), .S(s0), .Cout(c0), .Ovf(o0)
  );
  pipelined_ripple_adder #(.WIDTH(16), .STAGES(16)) u_sw1 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(ir1), .A(sw_a[15:0]), .B(sw_b[15:0]),
    .Cin(sw_cin), .Sub(sw_sub), .out_valid(ov1), .out_ready(sw_or), .S(s1), .Cout(c1), .Ovf(o1)
  );
  pipelined_ripple_adder #(.WIDTH(64), .STAGES(8)) u_sw2 (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(ir2), .A(sw_a), .B(sw_b),
    .Cin(sw_cin), .Sub(sw_sub), .out_valid(ov2), .out_ready(sw_or), .S(s2), .Cout(c2), .Ovf(o2)
  );

  always_comb begin
    sw_s[0] = {48'b0, s0}; sw_s[1] = {48'b0, s1}; sw_s[2] = s2;
    sw_ov[0] = ov0; sw_ov[1] = ov1; sw_ov[2] = ov2;
    sw_ir[0] = ir0; sw_ir[1] = ir1; sw_ir[2] = ir2;
    sw_c[0] = c0; sw_c[1] = c1; sw_c[2] = c2;
    sw_o[0] = o0; sw_o[1] = o1; sw_o[2] = o2;
  end

  typedef struct {
    logic [31:0] a, b;
    bit          cin, sub;
    logic [31:0] s;
    bit          c, o;
  } vec_t;

  typedef struct {
    logic [63:0] s;
    bit          c, o;
  } res_t;

  vec_t vt [8];
  res_t q [$];
  res_t sq [3][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands (unsigned for S/Cout, signed for Ovf).
  function automatic res_t ref_op(input int unsigned w, input logic [63:0] a, input logic [63:0] b,
                                  input bit cin, input bit sub);
    res_t               r;
    logic [63:0]        mask;
    logic [65:0]        ua, ub, sum;
    logic signed [67:0] sa, sb, sr, lim;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {2'b0, a & mask};
    ub   = {2'b0, b & mask};
    if (sub) begin
      sum = ua - ub;
      r.c = (ua >= ub);
    end else begin
      sum = ua + ub + {65'b0, cin};
      r.c = sum[w];
    end
    r.s = sum[63:0] & mask;
    lim = 68'sd1 <<< (w - 1);
    sa  = $signed({2'b0, ua});
    sb  = $signed({2'b0, ub});
    if (ua[w-1]) sa = sa - (lim <<< 1);
    if (ub[w-1]) sb = sb - (lim <<< 1);
    sr  = sub ? (sa - sb) : (sa + sb + $signed({67'b0, cin}));
    r.o = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  initial begin
    int   n, sent, got, extra;
    bit   found, held_v;
    logic [31:0] held_s;
    res_t e;
    int   cnt [3];
    int   first [3];
    int   last [3];
    int unsigned sw_w [3];
    localparam int N = 10000;

    sw_w = '{16, 16, 64};
    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0};
    vt[1] = '{32'h8000_0000, 32'h0000_0001, 0, 1, 32'h7FFF_FFFF, 1, 1};
    vt[2] = '{32'h0000_0005, 32'h0000_0007, 0, 1, 32'hFFFF_FFFE, 0, 0};
    vt[3] = '{32'h7FFF_FFFF, 32'h0000_0000, 1, 0, 32'h8000_0000, 0, 1};
    vt[4] = '{32'h0000_0000, 32'h0000_0000, 0, 1, 32'h0000_0000, 1, 0};
    vt[5] = '{32'h8000_0000, 32'h8000_0000, 0, 0, 32'h0000_0000, 1, 1};
    vt[6] = '{32'h0000_000A, 32'h0000_0003, 1, 1, 32'h0000_0007, 1, 0};
    vt[7] = '{32'h1234_5678, 32'h1111_1111, 1, 0, 32'h2345_678A, 0, 0};

    rst = 1'b1;
    m_iv = 0; m_a = '0; m_b = '0; m_cin = 0; m_sub = 0; m_or = 1;
    sw_iv = 0; sw_a = '0; sw_b = '0; sw_cin = 0; sw_sub = 0; sw_or = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {63'b0, m_ov}, 64'd0);
    check("reset_S", {32'b0, m_s}, 64'd0);
    check("reset_Cout", {63'b0, m_c}, 64'd0);
    check("reset_Ovf", {63'b0, m_o}, 64'd0);
    check("reset_in_ready", {63'b0, m_ir}, 64'd1);

    // Directed table: one op at a time, latency and result checked
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_a = vt[i].a; m_b = vt[i].b; m_cin = vt[i].cin; m_sub = vt[i].sub; m_iv = 1;
      @(posedge clk);
      #1 m_iv = 0;
      n = 1; found = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (m_ov) begin found = 1; break; end
        @(posedge clk);
        n++;
      end
      check($sformatf("vec%0d_latency", i), found ? 64'(n) : 64'hDEAD, 64'd4);
      check($sformatf("vec%0d_S", i), {32'b0, m_s}, {32'b0, vt[i].s});
      check($sformatf("vec%0d_Cout", i), {63'b0, m_c}, {63'b0, vt[i].c});
      check($sformatf("vec%0d_Ovf", i), {63'b0, m_o}, {63'b0, vt[i].o});
    end
    @(negedge clk);

    // Backpressure: 10 random ops, out_ready low for cycles 5..9
    sent = 0; got = 0; held_v = 0; held_s = '0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      @(negedge clk);
      m_or = !(c >= 5 && c <= 9);
      if (sent < 10) begin
        m_iv = 1; m_a = $urandom; m_b = $urandom; m_cin = $urandom_range(0, 1);
        m_sub = $urandom_range(0, 1);
      end else begin
        m_iv = 0;
      end
      #1;
      if (!m_or && m_ov) check("bp_in_ready_low", {63'b0, m_ir}, 64'd0);
      if (m_or) check("bp_in_ready_high", {63'b0, m_ir}, 64'd1);
      if (held_v && m_ov) check("bp_hold_S", {32'b0, m_s}, {32'b0, held_s});
      if (m_ov && m_or) begin
        if (q.size() == 0) begin
          check("bp_unexpected_result", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("bp_result%0d", got), {m_c, m_o, 30'b0, m_s}, {e.c, e.o, 30'b0, e.s[31:0]});
        end
        got++;
        held_v = 0;
      end else if (m_ov) begin
        held_v = 1;
        held_s = m_s;
      end
      if (m_iv && m_ir) begin
        q.push_back(ref_op(32, {32'b0, m_a}, {32'b0, m_b}, m_cin, m_sub));
        sent++;
      end
    end
    m_iv = 0; m_or = 1;
    check("bp_count", 64'(got), 64'd10);
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_ov) extra++;
    end
    check("bp_no_duplicates", 64'(extra), 64'd0);

    // Reset mid-flight: one result presented and three ops in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_iv = 1; m_a = $urandom; m_b = $urandom; m_cin = 0; m_sub = 0;
    end
    @(negedge clk);
    m_iv = 0;
    check("rst_pre_valid", {63'b0, m_ov}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", {63'b0, m_ov}, 64'd0);
    check("rst_S", {32'b0, m_s}, 64'd0);
    check("rst_Cout", {63'b0, m_c}, 64'd0);
    check("rst_Ovf", {63'b0, m_o}, 64'd0);
    @(negedge clk) rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (m_ov) extra++;
    end
    check("rst_no_stale", 64'(extra), 64'd0);

    // Parameter sweep at full throughput
    for (int d = 0; d < 3; d++) begin cnt[d] = 0; first[d] = -1; last[d] = -1; end
    for (int c = 0; c < N + 40; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (sw_ov[d]) begin
          if (sq[d].size() == 0) begin
            check($sformatf("sweep%0d_unexpected", d), 64'd1, 64'd0);
          end else begin
            e = sq[d].pop_front();
            check($sformatf("sweep%0d_S", d), sw_s[d], e.s);
            check($sformatf("sweep%0d_flags", d), {62'b0, sw_c[d], sw_o[d]}, {62'b0, e.c, e.o});
          end
          if (first[d] < 0) first[d] = c;
          last[d] = c;
          cnt[d]++;
        end
      end
      sw_iv  = (c < N);
      sw_a   = {$urandom, $urandom};
      sw_b   = ($urandom_range(0, 7) == 0) ? sw_a : {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) sw_a = '1;
      sw_cin = $urandom_range(0, 1);
      sw_sub = $urandom_range(0, 1);
      #1;
      for (int d = 0; d < 3; d++)
        if (sw_iv && sw_ir[d]) sq[d].push_back(ref_op(sw_w[d], sw_a, sw_b, sw_cin, sw_sub));
    end
    for (int d = 0; d < 3; d++) begin
      check($sformatf("sweep%0d_count", d), 64'(cnt[d]), 64'(N));
      check($sformatf("sweep%0d_throughput", d), 64'(last[d] - first[d] + 1), 64'(N));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
